idelay_tap_calib: RTL
=====================

// Module: idelay_tap_calib
// PURPOSE
//  Training controller for one IDELAYE3 in VAR_LOAD mode on an RGMII/DDR input lane.
//  Sweeps the delay tap, scores each tap from a per-cycle pass/fail from the downstream pattern checker,
//  finds the longest contiguous passing run (the eye) and loads its centre tap.
//  Sits beside the input DDR capture stage; drives CNTVALUEIN/LOAD/EN_VTC of the delay element.
// PARAMETERS
//  TAP_W           9    tap count width (IDELAYE3 CNTVALUE width)
//  TAP_MIN         0    first tap swept
//  TAP_MAX         511  last tap swept (inclusive, <= 2**TAP_W-1)
//  TAP_STEP        1    tap increment per step (>=1)
//  VTC_WAIT_CYCLES 16   cycles between EN_VTC low and first LOAD
//  SETTLE_CYCLES   8    cycles after LOAD before observing
//  WINDOW_CYCLES   256  valid samples scored per tap
//  RECAL_INTERVAL  2**24 cycles from done to auto-restart (IDELAY_CALIB_RECAL_EN only)
// PORTS
//  clk            in   1      clock; all logic on posedge
//  rst_n          in   1      synchronous reset, active-low
//  start          in   1      pulse: begin calibration (ignored while busy)
//  sample_valid   in   1      sample_ok qualifier
//  sample_ok      in   1      1 = checker saw expected pattern this cycle
//  cnt_value_in   out  TAP_W  tap to IDELAYE3 CNTVALUEIN
//  load           out  1      1-cycle pulse to IDELAYE3 LOAD
//  en_vtc         out  1      to IDELAYE3 EN_VTC
//  busy           out  1      calibration in progress
//  done           out  1      level: last calibration locked to a centre tap
//  fail           out  1      level: last calibration found no passing tap
//  eye_start      out  TAP_W  first tap of the winning run
//  eye_width      out  TAP_W+1 winning run length in taps (steps)
// BEHAVIOUR
//  Reset: cnt_value_in=TAP_MIN, load=0, en_vtc=1, busy=0, done=0, fail=0, eye_start=0, eye_width=0; state IDLE.
//  FSM: IDLE -start-> VTC_OFF (en_vtc=0, wait VTC_WAIT_CYCLES) -> LOAD (load=1 one cycle, cnt_value_in=tap)
//   -> SETTLE (SETTLE_CYCLES) -> OBSERVE -> NEXT -> LOAD | FINAL_LOAD -> FINAL_SETTLE -> VTC_ON -> IDLE.
//  start in IDLE clears done/fail, sets busy the next cycle, tap=TAP_MIN.
//  OBSERVE: window counter advances only when sample_valid=1; any sample_valid&!sample_ok marks tap bad;
//   exits after WINDOW_CYCLES valid samples (no timeout; stalled valid holds state).
//  NEXT: tap good -> extend current run (open at this tap if none); bad -> close run.
//   Closed run replaces best only if strictly longer (ties: lowest start wins).
//   If tap+TAP_STEP > TAP_MAX: close open run, go FINAL_LOAD; no tap wrap-around, no overflow.
//  Centre = eye_start + ((eye_width-1)>>1)*TAP_STEP, computed in TAP_W+1 bits; result never exceeds TAP_MAX.
//  FINAL_LOAD: best width>0 -> load centre; width=0 -> load TAP_MIN, set fail.
//  VTC_ON: en_vtc=1; busy=0 and done=!fail in same cycle; eye_start/eye_width update then, hold until next start.
//  load is asserted only while en_vtc=0; en_vtc never drops mid-transfer outside VTC_OFF..VTC_ON.
//  rst_n low mid-sweep: immediate return to reset values next edge; no final load issued.
// CONFIGURATION
//  IDELAY_CALIB_RECAL_EN defined: after done or fail, counter runs RECAL_INTERVAL cycles then
//   self-starts (identical to start pulse); start pulse restarts counter. Undefined: only start initiates; no counter.
// STRUCTURE
//  Package idelay_calib_pkg: FSM state enum, TAP_W default, centre-tap function.
//  Sub-module idelay_eye_tracker: run open/close, best-run compare, centre calc; FSM stays in top.
// TESTING
//  1 Checker passes only taps 100..180 (TAP_STEP=1) -> fail=0, eye_start=100, eye_width=81, final cnt_value_in=140.
//  2 Two runs 20..39 and 300..319 (equal width) -> eye_start=20, centre 29.
//  3 sample_ok always 0 -> fail=1, done=0, final cnt_value_in=TAP_MIN, en_vtc back to 1.
//  4 Passing run 480..511 at TAP_MAX -> run closed at end, eye_width=32, centre 495, no wrap.
//  5 rst_n low during OBSERVE at tap 200 -> next cycle all outputs at reset values; start again completes normally.
//  6 sample_valid held low 1000 cycles in OBSERVE -> state and tap hold; with IDELAY_CALIB_RECAL_EN,
//    RECAL_INTERVAL=1000 -> busy reasserts 1000 cycles after done.
//  All: assert load implies en_vtc=0; start while busy has no effect.

Source files
------------

// File: rtl/idelay_calib_pkg.sv
// Shared types and helpers for the IDELAYE3 tap-training controller.
package idelay_calib_pkg;

    localparam int unsigned TAP_W_DEF = 9;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_VTC_OFF,
        ST_LOAD,
        ST_SETTLE,
        ST_OBSERVE,
        ST_NEXT,
        ST_FINAL_LOAD,
        ST_FINAL_SETTLE,
        ST_VTC_ON
    } calib_state_e;

    // Centre of a run of 'width' taps starting at 'start'; never past the run's last tap.
    function automatic int unsigned centre_tap(input int unsigned start,
                                               input int unsigned width,
                                               input int unsigned step);
        if (width == 0) return start;
        return start + ((width - 1) >> 1) * step;
    endfunction

endpackage

// File: rtl/idelay_tap_calib_if.sv
// Delay-element control and pattern-checker status for one trained input lane.
interface idelay_tap_calib_if
    import idelay_calib_pkg::*;
#(
    parameter int unsigned TAP_W = TAP_W_DEF
);
    logic             sample_valid;
    logic             sample_ok;
    logic [TAP_W-1:0] cnt_value_in;
    logic             load;
    logic             en_vtc;

    modport master (
        input  sample_valid,
        input  sample_ok,
        output cnt_value_in,
        output load,
        output en_vtc
    );

    modport slave (
        output sample_valid,
        output sample_ok,
        input  cnt_value_in,
        input  load,
        input  en_vtc
    );
endinterface

// File: rtl/idelay_eye_tracker.sv
// Tracks the current passing run during a sweep and keeps the longest one (earliest on ties).
module idelay_eye_tracker
    import idelay_calib_pkg::*;
#(
    parameter int unsigned TAP_W    = TAP_W_DEF,
    parameter int unsigned TAP_MIN  = 0,
    parameter int unsigned TAP_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             step,
    input  logic [TAP_W-1:0] tap,
    input  logic             tap_good,
    input  logic             last,
    output logic [TAP_W-1:0] best_start,
    output logic [TAP_W:0]   best_width,
    output logic [TAP_W-1:0] centre_c
);
    localparam int unsigned WW = TAP_W + 1;

    logic             run_open;
    logic [TAP_W-1:0] run_start;
    logic [TAP_W:0]   run_width;

    logic [TAP_W-1:0] ext_start_c;
    logic [TAP_W:0]   ext_width_c;
    logic [TAP_W-1:0] cand_start_c;
    logic [TAP_W:0]   cand_width_c;
    logic             close_c;

    // A good tap extends the run; a bad tap or the final good tap closes it.
    always_comb begin
        ext_start_c  = run_open ? run_start : tap;
        ext_width_c  = run_open ? run_width + WW'(1) : WW'(1);
        cand_start_c = tap_good ? ext_start_c : run_start;
        cand_width_c = tap_good ? ext_width_c : run_width;
        close_c      = step && (tap_good ? last : run_open);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            run_open   <= 1'b0;
            run_start  <= TAP_W'(TAP_MIN);
            run_width  <= '0;
            best_start <= TAP_W'(TAP_MIN);
            best_width <= '0;
        end else if (step) begin
            if (tap_good && !last) begin
                run_open  <= 1'b1;
                run_start <= ext_start_c;
                run_width <= ext_width_c;
            end else begin
                run_open  <= 1'b0;
                run_width <= '0;
            end
            if (close_c && (cand_width_c > best_width)) begin
                best_start <= cand_start_c;
                best_width <= cand_width_c;
            end
        end
    end

    assign centre_c = TAP_W'(centre_tap(32'(best_start), 32'(best_width), TAP_STEP));

endmodule

// File: rtl/idelay_tap_calib.sv
// IDELAYE3 VAR_LOAD training: sweep taps, score each, load the centre of the widest eye.
// Define IDELAY_CALIB_RECAL_EN to self-restart RECAL_INTERVAL cycles after each result.
module idelay_tap_calib
    import idelay_calib_pkg::*;
#(
    parameter int unsigned TAP_W           = TAP_W_DEF,
    parameter int unsigned TAP_MIN         = 0,
    parameter int unsigned TAP_MAX         = 511,
    parameter int unsigned TAP_STEP        = 1,
    parameter int unsigned VTC_WAIT_CYCLES = 16,
    parameter int unsigned SETTLE_CYCLES   = 8,
    parameter int unsigned WINDOW_CYCLES   = 256
`ifdef IDELAY_CALIB_RECAL_EN
    ,
    parameter int unsigned RECAL_INTERVAL  = 2**24
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    idelay_tap_calib_if.master  lane,
    output logic                busy,
    output logic                done,
    output logic                fail,
    output logic [TAP_W-1:0]    eye_start,
    output logic [TAP_W:0]      eye_width
);
    localparam int unsigned CNT_W = $clog2(VTC_WAIT_CYCLES + SETTLE_CYCLES + WINDOW_CYCLES + 1);

    calib_state_e     state;
    logic [TAP_W-1:0] tap;
    logic [CNT_W-1:0] cnt;
    logic             tap_bad;

    logic [31:0]      tap_sum_c;
    logic             last_tap_c;
    logic             start_c;
    logic [TAP_W-1:0] best_start;
    logic [TAP_W:0]   best_width;
    logic [TAP_W-1:0] centre_c;

    // Wide sum so the end-of-sweep test cannot wrap.
    assign tap_sum_c  = 32'(tap) + 32'(TAP_STEP);
    assign last_tap_c = tap_sum_c > 32'(TAP_MAX);

`ifdef IDELAY_CALIB_RECAL_EN
    localparam int unsigned RECAL_W = $clog2(RECAL_INTERVAL);

    logic [RECAL_W-1:0] recal_cnt;
    logic               recal_fire_c;

    assign recal_fire_c = (state == ST_IDLE) && (done || fail) &&
                          (recal_cnt == RECAL_W'(RECAL_INTERVAL - 1));

    // Idle interval timer; restarts whenever a calibration leaves IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n || (state != ST_IDLE) || !(done || fail)) begin
            recal_cnt <= '0;
        end else if (!recal_fire_c) begin
            recal_cnt <= recal_cnt + RECAL_W'(1);
        end
    end

    assign start_c = start || recal_fire_c;
`else
    assign start_c = start;
`endif

    idelay_eye_tracker #(
        .TAP_W    (TAP_W),
        .TAP_MIN  (TAP_MIN),
        .TAP_STEP (TAP_STEP)
    ) u_eye (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      ((state == ST_IDLE) && start_c),
        .step       (state == ST_NEXT),
        .tap        (tap),
        .tap_good   (!tap_bad),
        .last       (last_tap_c),
        .best_start (best_start),
        .best_width (best_width),
        .centre_c   (centre_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= ST_IDLE;
            tap               <= TAP_W'(TAP_MIN);
            cnt               <= '0;
            tap_bad           <= 1'b0;
            lane.cnt_value_in <= TAP_W'(TAP_MIN);
            lane.load         <= 1'b0;
            lane.en_vtc       <= 1'b1;
            busy              <= 1'b0;
            done              <= 1'b0;
            fail              <= 1'b0;
            eye_start         <= '0;
            eye_width         <= '0;
        end else begin
            lane.load <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start_c) begin
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        fail        <= 1'b0;
                        tap         <= TAP_W'(TAP_MIN);
                        cnt         <= '0;
                        lane.en_vtc <= 1'b0;
                        state       <= ST_VTC_OFF;
                    end
                end
                ST_VTC_OFF: begin
                    if (cnt == CNT_W'(VTC_WAIT_CYCLES - 1)) begin
                        lane.load         <= 1'b1;
                        lane.cnt_value_in <= tap;
                        state             <= ST_LOAD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_LOAD: begin
                    cnt   <= '0;
                    state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        cnt     <= '0;
                        tap_bad <= 1'b0;
                        state   <= ST_OBSERVE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                // Only qualified samples advance the window; a stalled checker holds here.
                ST_OBSERVE: begin
                    if (lane.sample_valid) begin
                        if (!lane.sample_ok) tap_bad <= 1'b1;
                        if (cnt == CNT_W'(WINDOW_CYCLES - 1)) begin
                            state <= ST_NEXT;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_NEXT: begin
                    if (last_tap_c) begin
                        state <= ST_FINAL_LOAD;
                    end else begin
                        tap               <= TAP_W'(tap_sum_c);
                        lane.load         <= 1'b1;
                        lane.cnt_value_in <= TAP_W'(tap_sum_c);
                        state             <= ST_LOAD;
                    end
                end
                ST_FINAL_LOAD: begin
                    lane.load         <= 1'b1;
                    lane.cnt_value_in <= (best_width != '0) ? centre_c : TAP_W'(TAP_MIN);
                    cnt               <= '0;
                    state             <= ST_FINAL_SETTLE;
                end
                ST_FINAL_SETTLE: begin
                    if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        state <= ST_VTC_ON;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_VTC_ON: begin
                    lane.en_vtc <= 1'b1;
                    busy        <= 1'b0;
                    done        <= (best_width != '0);
                    fail        <= (best_width == '0);
                    eye_start   <= best_start;
                    eye_width   <= best_width;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
